// File: rtl/slice_result_collector.sv
// slice_result_collector
//   Downstream stage of the sliced inverter/OAI array. It captures one C
//   result word through a valid/ready handshake and then streams it out as
//   SLICE_W-bit slices. Only the slices enabled in SLICE_MASK are sent. The
//   block also counts the words it has fully emitted.
// Ports:
//   CK, RST        clock, asynchronous active-high reset
//   C_VALID/READY  upstream word handshake; C is the WIDTH-bit result word
//   S_VALID/READY  downstream slice handshake
//   S_DATA/IDX     slice payload (zero-extended) and its slice index
//   S_LAST/PAR     final enabled slice of the word, XOR-reduce of S_DATA
//   WORD_CNT       completed-word counter, wraps silently
module slice_result_collector #(
  parameter int unsigned               WIDTH      = 41,
  parameter int unsigned               SLICE_W    = 12,
  parameter int unsigned               NUM_SLICES = 4,
  parameter logic [NUM_SLICES-1:0]     SLICE_MASK = 4'b0101,
  parameter int unsigned               CNT_W      = 16
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               C_VALID,
  output logic               C_READY,
  input  logic [WIDTH-1:0]   C,
  output logic               S_VALID,
  input  logic               S_READY,
  output logic [SLICE_W-1:0] S_DATA,
  output logic [1:0]         S_IDX,
  output logic               S_LAST,
  output logic               S_PAR,
  output logic [CNT_W-1:0]   WORD_CNT
);

  localparam int unsigned PAD_W = NUM_SLICES * SLICE_W;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  logic               state_q, state_d;
  logic               rdy_q, rdy_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [1:0]         idx_q, idx_d;
  logic [SLICE_W-1:0] data_q, data_d;
  logic               last_q, last_d;
  logic               par_q, par_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         first_idx, next_idx;
  logic               first_found, next_found;

  // The word is zero-padded to a whole number of slices. That way the top
  // slice carries only the remaining upper bits.
  function automatic logic [SLICE_W-1:0] slice_of(input logic [WIDTH-1:0] w,
                                                  input logic [1:0] i);
    logic [PAD_W-1:0] p;
    p = '0;
    p[WIDTH-1:0] = w;
    return p[int'(i)*SLICE_W +: SLICE_W];
  endfunction

  function automatic logic is_last(input logic [1:0] i);
    logic l;
    l = 1'b1;
    for (int unsigned j = 0; j < NUM_SLICES; j++)
      if (SLICE_MASK[j] && (j > 32'(i))) l = 1'b0;
    return l;
  endfunction

  // The lowest enabled slice, and the next enabled slice above the current
  // pointer. Disabled slices are skipped here, so they take no cycles.
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    next_idx    = idx_q;
    next_found  = 1'b0;
    for (int unsigned j = 0; j < NUM_SLICES; j++) begin
      if (SLICE_MASK[j] && !first_found) begin
        first_idx   = 2'(j);
        first_found = 1'b1;
      end
      if (SLICE_MASK[j] && (j > 32'(idx_q)) && !next_found) begin
        next_idx   = 2'(j);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (C_VALID && rdy_q) begin
          if (SLICE_MASK == '0) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            // The first slice comes straight from C, because word_q only
            // loads on this same edge.
            word_d  = C;
            idx_d   = first_idx;
            data_d  = slice_of(C, first_idx);
            last_d  = is_last(first_idx);
            state_d = ST_SEND;
          end
        end
      end
      default: begin
        if (S_READY) begin
          if (last_q) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d  = next_idx;
            data_d = slice_of(word_q, next_idx);
            last_d = is_last(next_idx);
          end
        end
      end
    endcase
    par_d = ^data_d;
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      word_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
    end
  end

  assign C_READY  = rdy_q;
  assign S_VALID  = (state_q == ST_SEND);
  assign S_DATA   = data_q;
  assign S_IDX    = idx_q;
  assign S_LAST   = last_q;
  assign S_PAR    = par_q;
  assign WORD_CNT = cnt_q;

endmodule

// File: tb/tb_slice_result_collector.sv
module tb_slice_result_collector;

  logic CK = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;

  int checks = 0;
  int failures = 0;

  // a: default mask, f: all slices, z: no slices, w: 2-bit counter
  logic        a_cv, a_cr, a_sv, a_sr, a_sl, a_sp;
  logic [40:0] a_c;
  logic [11:0] a_sd;
  logic [1:0]  a_si;
  logic [15:0] a_cnt;

  logic        f_cv, f_cr, f_sv, f_sr, f_sl, f_sp;
  logic [40:0] f_c;
  logic [11:0] f_sd;
  logic [1:0]  f_si;
  logic [15:0] f_cnt;

  logic        z_cv, z_cr, z_sv, z_sr, z_sl, z_sp;
  logic [40:0] z_c;
  logic [11:0] z_sd;
  logic [1:0]  z_si;
  logic [15:0] z_cnt;

  logic        w_cv, w_cr, w_sv, w_sr, w_sl, w_sp;
  logic [40:0] w_c;
  logic [11:0] w_sd;
  logic [1:0]  w_si;
  logic [1:0]  w_cnt;

  slice_result_collector dut (
    .CK(CK), .RST(RST), .C_VALID(a_cv), .C_READY(a_cr), .C(a_c),
    .S_VALID(a_sv), .S_READY(a_sr), .S_DATA(a_sd), .S_IDX(a_si),
    .S_LAST(a_sl), .S_PAR(a_sp), .WORD_CNT(a_cnt));

  slice_result_collector #(.SLICE_MASK(4'b1111)) dut_f (
    .CK(CK), .RST(RST), .C_VALID(f_cv), .C_READY(f_cr), .C(f_c),
    .S_VALID(f_sv), .S_READY(f_sr), .S_DATA(f_sd), .S_IDX(f_si),
    .S_LAST(f_sl), .S_PAR(f_sp), .WORD_CNT(f_cnt));

  slice_result_collector #(.SLICE_MASK(4'b0000)) dut_z (
    .CK(CK), .RST(RST), .C_VALID(z_cv), .C_READY(z_cr), .C(z_c),
    .S_VALID(z_sv), .S_READY(z_sr), .S_DATA(z_sd), .S_IDX(z_si),
    .S_LAST(z_sl), .S_PAR(z_sp), .WORD_CNT(z_cnt));

  slice_result_collector #(.CNT_W(2)) dut_w (
    .CK(CK), .RST(RST), .C_VALID(w_cv), .C_READY(w_cr), .C(w_c),
    .S_VALID(w_sv), .S_READY(w_sr), .S_DATA(w_sd), .S_IDX(w_si),
    .S_LAST(w_sl), .S_PAR(w_sp), .WORD_CNT(w_cnt));

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    a_cv = 0; a_sr = 0; a_c = '0;
    f_cv = 0; f_sr = 0; f_c = '0;
    z_cv = 0; z_sr = 0; z_c = '0;
    w_cv = 0; w_sr = 0; w_c = '0;
    tick(); tick();
    checks++; if (a_cr !== 1'b0) begin failures++; $display("FAIL rst_cready got=%b exp=0", a_cr); end
    checks++; if (a_sv !== 1'b0) begin failures++; $display("FAIL rst_svalid got=%b exp=0", a_sv); end
    checks++; if ({a_sd, a_si, a_sl, a_sp} !== 16'h0) begin failures++; $display("FAIL rst_sout got=%h exp=0", {a_sd, a_si, a_sl, a_sp}); end
    checks++; if (a_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", a_cnt); end
    RST = 1'b0;
    tick();
    checks++; if (a_cr !== 1'b1) begin failures++; $display("FAIL rel_cready got=%b exp=1", a_cr); end
    checks++; if (a_sv !== 1'b0) begin failures++; $display("FAIL rel_svalid got=%b exp=0", a_sv); end
  endtask

  task automatic test_basic();
    a_c = 41'h1_5A5A_5A5A5A; a_cv = 1; a_sr = 1;
    tick();
    a_cv = 0;
    checks++; if ({a_sv, a_si, a_sd, a_sl, a_sp} !== {1'b1, 2'd0, 12'hA5A, 1'b0, 1'b0}) begin
      failures++; $display("FAIL basic_beat1 got v=%b i=%0d d=%h l=%b p=%b exp v=1 i=0 d=a5a l=0 p=0", a_sv, a_si, a_sd, a_sl, a_sp); end
    checks++; if (a_cr !== 1'b0) begin failures++; $display("FAIL basic_cready_send got=%b exp=0", a_cr); end
    tick();
    checks++; if ({a_sv, a_si, a_sd, a_sl, a_sp} !== {1'b1, 2'd2, 12'hA5A, 1'b1, 1'b0}) begin
      failures++; $display("FAIL basic_beat2 got v=%b i=%0d d=%h l=%b p=%b exp v=1 i=2 d=a5a l=1 p=0", a_sv, a_si, a_sd, a_sl, a_sp); end
    tick();
    checks++; if ({a_sv, a_cr} !== 2'b01) begin failures++; $display("FAIL basic_done got v=%b r=%b exp v=0 r=1", a_sv, a_cr); end
    checks++; if (a_cnt !== 16'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", a_cnt); end
  endtask

  task automatic test_backpressure();
    a_c = 41'h1_5A5A_5A5A5A; a_cv = 1; a_sr = 0;
    tick();
    a_cv = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({a_sv, a_si, a_sd, a_cr} !== {1'b1, 2'd0, 12'hA5A, 1'b0}) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b i=%0d d=%h r=%b exp v=1 i=0 d=a5a r=0", i, a_sv, a_si, a_sd, a_cr); end
      tick();
    end
    checks++; if ({a_sv, a_si, a_sd} !== {1'b1, 2'd0, 12'hA5A}) begin
      failures++; $display("FAIL bp_still got v=%b i=%0d d=%h exp v=1 i=0 d=a5a", a_sv, a_si, a_sd); end
    a_sr = 1;
    tick();
    checks++; if ({a_sv, a_si, a_sl} !== {1'b1, 2'd2, 1'b1}) begin
      failures++; $display("FAIL bp_resume got v=%b i=%0d l=%b exp v=1 i=2 l=1", a_sv, a_si, a_sl); end
    tick();
    checks++; if ({a_sv, a_cr, a_cnt} !== {1'b0, 1'b1, 16'd2}) begin
      failures++; $display("FAIL bp_done got v=%b r=%b cnt=%0d exp v=0 r=1 cnt=2", a_sv, a_cr, a_cnt); end
  endtask

  task automatic test_full_mask();
    logic [1:0]  e_idx [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [11:0] e_dat [4] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h01F};
    logic        e_par [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        e_lst [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    f_c = 41'h1F_FFFF_FFFFF; f_cv = 1; f_sr = 1;
    tick();
    f_cv = 0;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({f_sv, f_si, f_sd, f_sl, f_sp} !== {1'b1, e_idx[k], e_dat[k], e_lst[k], e_par[k]}) begin
        failures++; $display("FAIL full_beat%0d got v=%b i=%0d d=%h l=%b p=%b exp v=1 i=%0d d=%h l=%b p=%b",
          k, f_sv, f_si, f_sd, f_sl, f_sp, e_idx[k], e_dat[k], e_lst[k], e_par[k]); end
      tick();
    end
    checks++; if ({f_sv, f_cnt} !== {1'b0, 16'd1}) begin
      failures++; $display("FAIL full_done got v=%b cnt=%0d exp v=0 cnt=1", f_sv, f_cnt); end
  endtask

  task automatic test_zero_mask();
    z_c = 41'h0_1234_5678; z_cv = 1; z_sr = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if ({z_sv, z_cr, z_cnt} !== {1'b0, 1'b1, 16'(k)}) begin
        failures++; $display("FAIL zero_word%0d got v=%b r=%b cnt=%0d exp v=0 r=1 cnt=%0d", k, z_sv, z_cr, z_cnt, k); end
    end
    z_cv = 0;
    tick();
    checks++; if ({z_sv, z_cnt} !== {1'b0, 16'd3}) begin
      failures++; $display("FAIL zero_final got v=%b cnt=%0d exp v=0 cnt=3", z_sv, z_cnt); end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] e_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    w_sr = 1;
    for (int k = 0; k < 5; k++) begin
      w_c = 41'h0_0000_0ABC; w_cv = 1;
      tick();
      w_cv = 0;
      tick();
      tick();
      checks++; if (w_cnt !== e_cnt[k]) begin
        failures++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", k, w_cnt, e_cnt[k]); end
    end
  endtask

  task automatic test_reset_mid_send();
    a_c = 41'h123_4567_89A; a_cv = 1; a_sr = 1;
    tick();
    a_cv = 0; a_sr = 0;
    tick();
    #3 RST = 1'b1;
    #1;
    checks++; if ({a_sv, a_cr, a_sd, a_si, a_sl, a_sp} !== 18'h0) begin
      failures++; $display("FAIL midrst_clear got v=%b r=%b d=%h i=%0d l=%b p=%b exp all 0", a_sv, a_cr, a_sd, a_si, a_sl, a_sp); end
    checks++; if (a_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", a_cnt); end
    tick();
    RST = 1'b0;
    a_sr = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (a_sv !== 1'b0) begin failures++; $display("FAIL midrst_idle%0d got v=%b exp 0", k, a_sv); end
    end
    a_cv = 1;
    tick();
    a_cv = 0;
    checks++; if ({a_sv, a_si, a_sd, a_sl, a_sp} !== {1'b1, 2'd0, 12'h89A, 1'b0, 1'b1}) begin
      failures++; $display("FAIL midrst_beat1 got v=%b i=%0d d=%h l=%b p=%b exp v=1 i=0 d=89a l=0 p=1", a_sv, a_si, a_sd, a_sl, a_sp); end
    tick();
    checks++; if ({a_sv, a_si, a_sd, a_sl, a_sp} !== {1'b1, 2'd2, 12'h234, 1'b1, 1'b0}) begin
      failures++; $display("FAIL midrst_beat2 got v=%b i=%0d d=%h l=%b p=%b exp v=1 i=2 d=234 l=1 p=0", a_sv, a_si, a_sd, a_sl, a_sp); end
    tick();
    checks++; if ({a_sv, a_cnt} !== {1'b0, 16'd1}) begin
      failures++; $display("FAIL midrst_done got v=%b cnt=%0d exp v=0 cnt=1", a_sv, a_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full_mask();
    test_zero_mask();
    test_cnt_wrap();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slice_result_collector.md
Name: slice_result_collector

Overview:
- Downstream stage of the 41-bit sliced inverter/OAI array.
- Registers the array's 41-bit C result word through a valid/ready handshake.
- Serialises the word as a stream of 12-bit slices on a second valid/ready interface.
- Skips slices whose array instance leaves its C output unconnected, and counts completed words.

Parameters:
- WIDTH, 41, width of the captured result word C.
- SLICE_W, 12, width of one output slice.
- NUM_SLICES, 4, number of slices per word (ceil(WIDTH/SLICE_W)).
- SLICE_MASK, 4'b0101, bit i = 1 means slice i is emitted. The default emits slices 0 and 2; slices 1 and 3 are undriven in the array.
- CNT_W, 16, width of the completed-word counter.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- C_VALID  input  1  upstream result word valid.
- C_READY  output  1  collector can accept a word.
- C  input  WIDTH  result word from the array.
- S_VALID  output  1  output slice valid.
- S_READY  input  1  downstream accepts the slice.
- S_DATA  output  SLICE_W  slice payload.
- S_IDX  output  2  slice index 0..NUM_SLICES-1.
- S_LAST  output  1  final enabled slice of the current word.
- S_PAR  output  1  even parity, equal to XOR-reduce of S_DATA.
- WORD_CNT  output  CNT_W  number of fully emitted words.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - C_READY = 0 while RST is high; 1 from the first edge after release.
  - S_VALID, S_DATA, S_IDX, S_LAST, S_PAR and WORD_CNT = 0.
  - Word register = 0.
- States:
  - IDLE: C_READY = 1, S_VALID = 0.
  - SEND: C_READY = 0, S_VALID = 1.
- Word acceptance in IDLE (C_VALID & C_READY on edge N):
  - Capture C into the word register.
  - Load the slice pointer with the lowest set bit of SLICE_MASK.
  - Enter SEND; the first slice is valid at cycle N+1 (latency 1).
- Slice mapping:
  - Slice i = word[min(i*SLICE_W+SLICE_W-1, WIDTH-1) : i*SLICE_W].
  - Zero-extended to SLICE_W. Slice 3 carries C[40:36] in S_DATA[4:0]; S_DATA[11:5] = 0.
- Output timing:
  - S_DATA, S_IDX, S_LAST and S_PAR are registered.
  - They are held stable while S_VALID & !S_READY, with no change until the handshake completes.
- Slice handshake in SEND (S_VALID & S_READY):
  - If not the last slice: advance to the next set mask bit above the current index. Disabled slices consume no cycles.
  - If S_LAST: WORD_CNT += 1 and return to IDLE. A new word can be accepted on the following edge, so sustained throughput is one word per (enabled_slices+1) cycles.
- S_LAST is 1 exactly when no higher mask bit is set.
- SLICE_MASK == 0:
  - Every accepted word is counted in the same edge (WORD_CNT += 1).
  - State stays IDLE; S_VALID is never asserted.
- WORD_CNT wraps from 2^CNT_W-1 to 0 with no flag.
- C_VALID while in SEND is ignored; the upstream must hold the word until C_READY.
- Reset mid-SEND: the partial word is discarded, WORD_CNT is cleared, and no slice is emitted after release until a new word arrives.
- S_READY high with S_VALID low has no effect.

Test Plan:
- Reset, then C = 41'h1_5A5A_5A5A5A with default mask and S_READY held 1. Required:
  - Two beats on consecutive cycles starting 1 cycle after acceptance.
  - Beat 1: S_IDX=0, S_DATA=12'hA5A, S_LAST=0, S_PAR=0.
  - Beat 2: S_IDX=2, S_DATA=12'hA5A, S_LAST=1.
  - WORD_CNT=1, C_READY=1 on the next cycle.
- Backpressure: S_READY=0 for 5 cycles on beat 1. Required: S_VALID, S_DATA and S_IDX held constant, C_READY=0 throughout, and emission resumes on the first cycle S_READY=1.
- SLICE_MASK=4'b1111, C=41'h1F_FFFF_FFFFF. Required:
  - Indices 0,1,2 with S_DATA=12'hFFF each.
  - Index 3 with S_DATA=12'h01F and S_LAST=1.
  - S_PAR = 0, 0, 0, 1 respectively.
- SLICE_MASK=0: accept 3 words back to back. Required: S_VALID never high, WORD_CNT=3, C_READY stays 1.
- Assert RST asynchronously mid-SEND, between beats. Required: outputs clear immediately, WORD_CNT=0, no S_VALID after release, and the next word is emitted normally from index 0.
- CNT_W=2: send 5 words. Required: WORD_CNT sequence 1,2,3,0,1.
